// File: rtl/seq_signed_divider_if.sv
// Start/done handshake bundle for the sequential signed divider.
// The arithmetic-unit controller uses the master side; the divider uses the slave side.
interface seq_signed_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: radix-2 restoring division on operand magnitudes,
// followed by a one-cycle sign fix-up. Truncating semantics (quotient toward zero,
// remainder takes the dividend's sign). Fixed latency of WIDTH+1 cycles.
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_signed_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] q_reg;          // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH:0]   r_reg;          // partial remainder
  logic [WIDTH:0]   dvs_mag_reg;    // |divisor|; WIDTH+1 bits so |-2^(WIDTH-1)| fits with margin
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             dbz_pend_reg;
  logic             ovf_pend_reg;

  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_fix;

  // A new operation is only taken while no operation is in flight.
  assign accept = (state_reg == IDLE) && bus.start;

  // An unsigned WIDTH-bit value holds 2^(WIDTH-1), so the most-negative dividend
  // negates cleanly into its magnitude.
  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_ext = {bus.divisor[WIDTH-1], bus.divisor};
  assign dvs_mag = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;

  // One restoring step: shift {R,Q} left, try subtracting the divisor magnitude.
  assign r_shift  = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign trial    = {1'b0, r_shift} - {1'b0, dvs_mag_reg};
  assign trial_ok = ~trial[WIDTH+1];
  assign r_next   = trial_ok ? trial[WIDTH:0] : r_shift;

  assign q_fix = sign_q_reg ? -q_reg : q_reg;

  // State register; reset returns to IDLE and abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> CALC on accept, CALC for WIDTH cycles, one FIX cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (count_reg == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      dvs_mag_reg   <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      dbz_pend_reg  <= 1'b0;
      ovf_pend_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            q_reg        <= dvd_mag;
            r_reg        <= '0;
            dvs_mag_reg  <= dvs_mag;
            sign_q_reg   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r_reg   <= bus.dividend[WIDTH-1];
            dbz_pend_reg <= (bus.divisor == '0);
            ovf_pend_reg <= (bus.dividend == MOST_NEG) && (&bus.divisor);
            count_reg    <= CW'(WIDTH);
            busy_reg     <= 1'b1;
          end
        end
        CALC: begin
          r_reg     <= r_next;
          q_reg     <= {q_reg[WIDTH-2:0], trial_ok};
          count_reg <= count_reg - CW'(1);
        end
        FIX: begin
          // With a zero divisor the iteration leaves R = |dividend|, so the
          // remainder path already yields the dividend; only the quotient is forced.
          quotient_reg  <= dbz_pend_reg ? '1 : q_fix;
          remainder_reg <= WIDTH'(sign_r_reg ? -r_reg : r_reg);
          dbz_reg       <= dbz_pend_reg;
          ovf_reg       <= ovf_pend_reg;
          done_reg      <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed cases at WIDTH=8 and a
// shuffled exhaustive sweep at WIDTH=4, checked against a truncating-division model.
module tb_seq_signed_divider;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seq_signed_divider_if #(.WIDTH(8)) bus8();
  seq_signed_divider_if #(.WIDTH(4)) bus4();

  seq_signed_divider #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_signed_divider #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // Reference: C-style truncating division with the divider's special cases.
  function automatic void ref_div(input int w, input int a, input int b,
                                  output int q, output int r, output bit dz, output bit ov);
    int mn;
    mn = -(1 << (w - 1));
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = -1; r = a; dz = 1'b1;
    end else if (a == mn && b == -1) begin
      q = mn; r = 0; ov = 1'b1;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  task automatic drive(input int w, input bit s, input int a, input int b);
    if (w == 8) begin
      bus8.start = s; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
    end else begin
      bus4.start = s; bus4.dividend = a[3:0]; bus4.divisor = b[3:0];
    end
  endtask

  task automatic sample(input int w, output int q, output int r, output bit dn,
                        output bit bsy, output bit dz, output bit ov);
    if (w == 8) begin
      q = int'($signed(bus8.quotient)); r = int'($signed(bus8.remainder));
      dn = bus8.done; bsy = bus8.busy; dz = bus8.div_by_zero; ov = bus8.overflow;
    end else begin
      q = int'($signed(bus4.quotient)); r = int'($signed(bus4.remainder));
      dn = bus4.done; bsy = bus4.busy; dz = bus4.div_by_zero; ov = bus4.overflow;
    end
  endtask

  // Issues one operation and reports results, latency (edges after acceptance,
  // -1 if done never came) and handshake observations. Does no comparing itself.
  task automatic run_op(input int w, input int a, input int b,
                        output int q, output int r, output bit dz, output bit ov,
                        output int lat, output bit busy_ok, output bit held_ok,
                        output bit single_ok);
    int q0, r0, qq, rr;
    bit dn, bsy, d0, o0, dd, oo;
    q = 0; r = 0; dz = 1'b0; ov = 1'b0; lat = -1;
    busy_ok = 1'b1; held_ok = 1'b1;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(negedge clk);
    drive(w, 1'b0, int'($urandom), int'($urandom));
    sample(w, q0, r0, dn, bsy, d0, o0);
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      sample(w, qq, rr, dn, bsy, dd, oo);
      if (dn) begin
        lat = c;
        if (bsy) busy_ok = 1'b0;
        q = qq; r = rr; dz = dd; ov = oo;
        break;
      end
      if (!bsy) busy_ok = 1'b0;
      if (qq !== q0 || rr !== r0 || dd !== d0 || oo !== o0) held_ok = 1'b0;
    end
    @(negedge clk);
    sample(w, qq, rr, dn, bsy, dd, oo);
    single_ok = !dn;
    $display("op w=%0d %0d / %0d -> q=%0d r=%0d dz=%0d ov=%0d lat=%0d", w, a, b, q, r, dz, ov, lat);
  endtask

  task automatic test_reset();
    int q, r;
    bit dn, bsy, dz, ov;
    reset = 1'b1;
    drive(8, 1'b1, 7, 2);
    drive(4, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    for (int w = 4; w <= 8; w += 4) begin
      sample(w, q, r, dn, bsy, dz, ov);
      checks++;
      if ({q, r, dn, bsy, dz, ov} !== {32'sd0, 32'sd0, 4'b0000}) begin
        errors++;
        $display("FAIL reset_state w=%0d: got q=%0d r=%0d done=%0d busy=%0d dz=%0d ov=%0d, want all 0",
                 w, q, r, dn, bsy, dz, ov);
      end
    end
    reset = 1'b0;
    drive(8, 1'b0, 0, 0);
    $display("reset released");
  endtask

  task automatic test_basic();
    int q, r, lat;
    bit dz, ov, bok, hok, sok;
    run_op(8, 7, 2, q, r, dz, ov, lat, bok, hok, sok);
    checks++;
    if (q !== 3 || r !== 1) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d, want q=3 r=1", q, r);
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL basic_latency: got %0d, want 9", lat);
    end
    checks++;
    if ({dz, ov} !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got dz=%0d ov=%0d, want 0 0", dz, ov);
    end
    checks++;
    if ({bok, hok, sok} !== 3'b111) begin
      errors++; $display("FAIL basic_handshake: busy_ok=%0d held_ok=%0d single_done=%0d, want 1 1 1", bok, hok, sok);
    end
  endtask

  // Runs a table of WIDTH=8 operations through the model.
  task automatic test_table8(input string name, input int ta[], input int tbv[]);
    int q, r, lat, eq, er;
    bit dz, ov, edz, eov, bok, hok, sok;
    foreach (ta[i]) begin
      ref_div(8, ta[i], tbv[i], eq, er, edz, eov);
      run_op(8, ta[i], tbv[i], q, r, dz, ov, lat, bok, hok, sok);
      checks++;
      if ({q, r, dz, ov, lat} !== {eq, er, edz, eov, 32'sd9}) begin
        errors++;
        $display("FAIL %s %0d/%0d: got q=%0d r=%0d dz=%0d ov=%0d lat=%0d, want q=%0d r=%0d dz=%0d ov=%0d lat=9",
                 name, ta[i], tbv[i], q, r, dz, ov, lat, eq, er, edz, eov);
      end
      checks++;
      if ({bok, hok, sok} !== 3'b111) begin
        errors++;
        $display("FAIL %s_handshake %0d/%0d: busy_ok=%0d held_ok=%0d single_done=%0d, want 1 1 1",
                 name, ta[i], tbv[i], bok, hok, sok);
      end
    end
  endtask

  task automatic test_sign_matrix();
    int ta[] = '{-7, 7, -7, 0, 127};
    int tbv[] = '{2, -2, -2, 5, 1};
    test_table8("sign_matrix", ta, tbv);
  endtask

  task automatic test_special();
    int ta[] = '{-128, 5, -128, -128, 127, -1};
    int tbv[] = '{-1, 0, 0, 1, -128, -128};
    int q, r, lat;
    bit dz, ov, bok, hok, sok;
    test_table8("special", ta, tbv);
    // Hard values for the most-negative / -1 case, independent of the model.
    run_op(8, -128, -1, q, r, dz, ov, lat, bok, hok, sok);
    checks++;
    if ({q, r, dz, ov} !== {-32'sd128, 32'sd0, 2'b01}) begin
      errors++; $display("FAIL overflow_case: got q=%0d r=%0d dz=%0d ov=%0d, want -128 0 0 1", q, r, dz, ov);
    end
  endtask

  task automatic test_ignore_start();
    int q, r, lat, qq, rr;
    bit dn, bsy, dz, ov, extra;
    lat = -1; q = 0; r = 0;
    @(negedge clk);
    drive(8, 1'b1, 100, 7);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 0) drive(8, 1'b0, 0, 0);
      if (c == 2) drive(8, 1'b1, 9, 3);
      if (c == 3) drive(8, 1'b0, 0, 0);
      sample(8, qq, rr, dn, bsy, dz, ov);
      if (dn) begin lat = c; q = qq; r = rr; break; end
    end
    checks++;
    if ({q, r, lat} !== {32'sd14, 32'sd2, 32'sd9}) begin
      errors++; $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want q=14 r=2 lat=9", q, r, lat);
    end
    extra = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++; $display("FAIL ignore_start_no_second_op: saw busy/done after op, got %0d want 0", extra);
    end
    $display("ignored-start op: 100/7 -> q=%0d r=%0d lat=%0d", q, r, lat);
  endtask

  task automatic test_back_to_back();
    int qs[$], rs[$], cyc[$];
    int qq, rr;
    bit dn, bsy, dz, ov, done_after;
    done_after = 1'b0;
    @(negedge clk);
    drive(8, 1'b1, 9, 3);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      sample(8, qq, rr, dn, bsy, dz, ov);
      if (c == 10) begin
        drive(8, 1'b0, 0, 0);
        done_after = dn;
      end
      if (dn) begin qs.push_back(qq); rs.push_back(rr); cyc.push_back(c); end
      if (cyc.size() == 2) break;
    end
    checks++;
    if (cyc.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d done pulses, want 2", cyc.size());
    end else begin
      checks++;
      if ({cyc[0], cyc[1]} !== {32'sd9, 32'sd19}) begin
        errors++; $display("FAIL b2b_timing: got done at %0d and %0d, want 9 and 19", cyc[0], cyc[1]);
      end
      checks++;
      if ({qs[0], rs[0], qs[1], rs[1]} !== {32'sd3, 32'sd0, 32'sd3, 32'sd0}) begin
        errors++; $display("FAIL b2b_result: got q=%0d,%0d r=%0d,%0d, want q=3,3 r=0,0", qs[0], qs[1], rs[0], rs[1]);
      end
    end
    checks++;
    if (done_after !== 1'b0) begin
      errors++; $display("FAIL b2b_single_done: done after pulse got %0d, want 0", done_after);
    end
    repeat (2) @(negedge clk);
    $display("back-to-back 9/3 twice: done pulses=%0d", cyc.size());
  endtask

  task automatic test_reset_midop();
    int q, r, lat;
    bit dn, bsy, dz, ov, bok, hok, sok, saw_done;
    @(negedge clk);
    drive(8, 1'b1, -100, 9);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 0) drive(8, 1'b0, 0, 0);
      if (c == 3) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    sample(8, q, r, dn, bsy, dz, ov);
    checks++;
    if ({q, r, dn, bsy, dz, ov} !== {32'sd0, 32'sd0, 4'b0000}) begin
      errors++;
      $display("FAIL midop_reset_state: got q=%0d r=%0d done=%0d busy=%0d dz=%0d ov=%0d, want all 0",
               q, r, dn, bsy, dz, ov);
    end
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL midop_no_done: got done=%0d after abort, want 0", saw_done);
    end
    run_op(8, -100, 9, q, r, dz, ov, lat, bok, hok, sok);
    checks++;
    if ({q, r, lat} !== {-32'sd11, -32'sd1, 32'sd9}) begin
      errors++; $display("FAIL midop_restart: got q=%0d r=%0d lat=%0d, want q=-11 r=-1 lat=9", q, r, lat);
    end
  endtask

  task automatic test_sweep4();
    int order[256];
    int q, r, lat, eq, er, a, b, tmp, j;
    bit dz, ov, edz, eov, bok, hok, sok;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      a = ((order[i] >> 4) ^ 8) - 8;
      b = ((order[i] & 15) ^ 8) - 8;
      ref_div(4, a, b, eq, er, edz, eov);
      run_op(4, a, b, q, r, dz, ov, lat, bok, hok, sok);
      checks++;
      if ({q, r, dz, ov, lat} !== {eq, er, edz, eov, 32'sd5}) begin
        errors++;
        $display("FAIL sweep4 %0d/%0d: got q=%0d r=%0d dz=%0d ov=%0d lat=%0d, want q=%0d r=%0d dz=%0d ov=%0d lat=5",
                 a, b, q, r, dz, ov, lat, eq, er, edz, eov);
      end
      checks++;
      if ({bok, hok, sok} !== 3'b111) begin
        errors++;
        $display("FAIL sweep4_handshake %0d/%0d: busy_ok=%0d held_ok=%0d single_done=%0d, want 1 1 1",
                 a, b, bok, hok, sok);
      end
    end
  endtask

  task automatic test_random8();
    int ta[] = new[30];
    int tbv[] = new[30];
    foreach (ta[i]) begin
      ta[i] = (int'($urandom_range(255, 0)) ^ 128) - 128;
      tbv[i] = (int'($urandom_range(255, 0)) ^ 128) - 128;
    end
    test_table8("random8", ta, tbv);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_matrix();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random8();
    test_sweep4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
